// File: rtl/mem_stage_if.sv
// Data-SRAM request/response bundle between the memory stage and the data SRAM.
// master: stage side (drives req/wr/we/addr/wdata, receives addr_ok/data_ok/rdata).
// slave : SRAM side (the mirror image).
interface mem_stage_if;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    logic              data_sram_req;
    logic              data_sram_wr;
    logic [BE_W-1:0]   data_sram_we;
    logic [DATA_W-1:0] data_sram_addr;
    logic [DATA_W-1:0] data_sram_wdata;
    logic              data_sram_addr_ok;
    logic              data_sram_data_ok;
    logic [DATA_W-1:0] data_sram_rdata;

    modport master (
        output data_sram_req,
        output data_sram_wr,
        output data_sram_we,
        output data_sram_addr,
        output data_sram_wdata,
        input  data_sram_addr_ok,
        input  data_sram_data_ok,
        input  data_sram_rdata
    );

    modport slave (
        input  data_sram_req,
        input  data_sram_wr,
        input  data_sram_we,
        input  data_sram_addr,
        input  data_sram_wdata,
        output data_sram_addr_ok,
        output data_sram_data_ok,
        output data_sram_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: runs ld.w/st.w over a req/addr_ok/data_ok
// data SRAM, forwards the pending register write to the decoder and
// registers the writeback bundle.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   EX_to_MEM_reg       138-bit execute->memory register (held by upstream)
//   EX_to_MEM_fire      upstream reloads EX_to_MEM_reg this cycle
//   WB_allowin          writeback accepts this cycle
//   MEM_allowin         stage accepts a new entry
//   MEM_front_*         forwarding info for the decoder
//   dsram               data-SRAM interface (master side)
//   MEM_to_WB_reg       71-bit registered bundle for writeback
module mem_stage (
    input  logic          clk,
    input  logic          rst,
    input  logic [137:0]  EX_to_MEM_reg,
    input  logic          EX_to_MEM_fire,
    input  logic          WB_allowin,
    output logic          MEM_allowin,
    output logic          MEM_front_valid,
    output logic          MEM_front_ready,
    output logic [4:0]    MEM_front_addr,
    output logic [31:0]   MEM_front_data,
    mem_stage_if.master   dsram,
    output logic [70:0]   MEM_to_WB_reg
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] ir;
        logic              inst_ld_w;
        logic              mem_we;
        logic              res_from_mem;
        logic              gr_we;
        logic [DATA_W-1:0] rkd_value;
        logic [REG_W-1:0]  rf_waddr;
        logic [DATA_W-1:0] compute_result;
    } ex_mem_t;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] pc;
        logic              gr_we;
        logic [REG_W-1:0]  rf_waddr;
        logic [DATA_W-1:0] final_result;
    } mem_wb_t;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t            r_state;
    logic              r_done;
    logic              r_req;
    logic [DATA_W-1:0] r_rdata_buf;
    mem_wb_t           r_wb;

    ex_mem_t           w_ex;
    logic              w_mem_op;
    logic              w_live;
    logic              w_readygo;
    logic              w_handoff;
    logic [DATA_W-1:0] w_final_result;
    logic              w_unused_ex;

    // Field decode of the upstream register
    assign w_ex        = ex_mem_t'(EX_to_MEM_reg);
    assign w_unused_ex = ^{w_ex.ir, w_ex.inst_ld_w};

    assign w_mem_op  = w_ex.res_from_mem | w_ex.mem_we;
    // done marks an entry already handed off while upstream still holds it
    assign w_live    = w_ex.valid & ~r_done;
    assign w_readygo = w_live & ((~w_mem_op & (r_state == IDLE)) | (r_state == DONE));
    assign w_handoff = w_readygo & WB_allowin;

    // Load data only ever comes from the buffer, never raw rdata
    assign w_final_result = w_ex.res_from_mem ? r_rdata_buf : w_ex.compute_result;

    assign MEM_allowin     = ~w_ex.valid | r_done | w_handoff;
    assign MEM_front_valid = w_live & w_ex.gr_we;
    assign MEM_front_ready = ~w_ex.res_from_mem | (r_state == DONE);
    assign MEM_front_addr  = w_ex.rf_waddr;
    assign MEM_front_data  = w_final_result;

    // Request fields come straight from the held upstream register
    assign dsram.data_sram_req   = r_req;
    assign dsram.data_sram_wr    = w_ex.mem_we;
    assign dsram.data_sram_we    = w_ex.mem_we ? 4'hF : 4'h0;
    assign dsram.data_sram_addr  = w_ex.compute_result;
    assign dsram.data_sram_wdata = w_ex.rkd_value;

    assign MEM_to_WB_reg = r_wb;

    // Transaction FSM, done flag and writeback register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_done      <= 1'b0;
            r_req       <= 1'b0;
            r_rdata_buf <= '0;
            r_wb        <= '0;
        end else begin
            if (EX_to_MEM_fire) begin
                r_done <= 1'b0;
            end else if (w_handoff) begin
                r_done <= 1'b1;
            end

            if (w_handoff) begin
                r_wb.valid        <= 1'b1;
                r_wb.pc           <= w_ex.pc;
                r_wb.gr_we        <= w_ex.gr_we;
                r_wb.rf_waddr     <= w_ex.rf_waddr;
                r_wb.final_result <= w_final_result;
            end else if (WB_allowin) begin
                r_wb.valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_live && w_mem_op) begin
                        r_state <= REQ;
                        r_req   <= 1'b1;
                    end
                end
                REQ: begin
                    if (dsram.data_sram_addr_ok) begin
                        r_state <= WAIT;
                        r_req   <= 1'b0;
                    end
                end
                WAIT: begin
                    if (dsram.data_sram_data_ok) begin
                        if (w_ex.res_from_mem) begin
                            r_rdata_buf <= dsram.data_sram_rdata;
                        end
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (WB_allowin) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: the bench plays upstream register, data SRAM
// and writeback; expected writeback bundles go through a scoreboard queue.
module tb_mem_stage;
    logic         clk;
    logic         rst;
    logic [137:0] ex_reg;
    logic         fire;
    logic         wb_allowin;
    logic         mem_allowin;
    logic         front_valid;
    logic         front_ready;
    logic [4:0]   front_addr;
    logic [31:0]  front_data;
    logic [70:0]  mem_to_wb;

    mem_stage_if sram_if ();

    mem_stage dut (
        .clk             (clk),
        .rst             (rst),
        .EX_to_MEM_reg   (ex_reg),
        .EX_to_MEM_fire  (fire),
        .WB_allowin      (wb_allowin),
        .MEM_allowin     (mem_allowin),
        .MEM_front_valid (front_valid),
        .MEM_front_ready (front_ready),
        .MEM_front_addr  (front_addr),
        .MEM_front_data  (front_data),
        .dsram           (sram_if),
        .MEM_to_WB_reg   (mem_to_wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int handoffs = 0;
    int accepted = 0;
    logic [70:0] sb_q[$];

    task automatic chk(input string tag, input logic [137:0] obs, input logic [137:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [137:0] mk_ex(input logic v, input logic [31:0] pc,
                                           input logic we, input logic rfm, input logic gw,
                                           input logic [31:0] rkd, input logic [4:0] wa,
                                           input logic [31:0] cr);
        return {v, pc, pc ^ 32'h0000_FFFF, rfm, we, rfm, gw, rkd, wa, cr};
    endfunction

    function automatic logic [70:0] mk_wb(input logic [31:0] pc, input logic gw,
                                          input logic [4:0] wa, input logic [31:0] res);
        return {1'b1, pc, gw, wa, res};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Upstream loads a new entry: fire this cycle, register valid next cycle
    task automatic fire_load(input logic [137:0] e);
        fire = 1'b1;
        tick();
        ex_reg = e;
        fire   = 1'b0;
    endtask

    // Writeback-side monitor: a valid bundle after an edge where WB accepted is a new handoff
    logic mon_wb;
    logic mon_rst;
    logic [70:0] mon_exp;
    always begin
        @(posedge clk);
        mon_wb  = wb_allowin;
        mon_rst = rst;
        if (!mon_rst && sram_if.data_sram_req && sram_if.data_sram_addr_ok) accepted++;
        #2;
        if (!mon_rst && mon_wb && mem_to_wb[70]) begin
            handoffs++;
            checks++;
            assert (sb_q.size() != 0) else begin
                errors++;
                $error("FAIL wb_unexpected: observed %h expected no handoff", mem_to_wb);
            end
            if (sb_q.size() != 0) begin
                mon_exp = sb_q.pop_front();
                chk("wb_bundle", 138'(mem_to_wb), 138'(mon_exp));
            end
        end
    end

    logic [137:0] e;
    logic [137:0] bb[4];
    int h0;
    int a0;

    initial begin
        rst        = 1'b1;
        ex_reg     = '0;
        fire       = 1'b0;
        wb_allowin = 1'b1;
        sram_if.data_sram_addr_ok = 1'b0;
        sram_if.data_sram_data_ok = 1'b0;
        sram_if.data_sram_rdata   = '0;

        // Reset state
        tick();
        tick();
        chk("rst_wb_reg", 138'(mem_to_wb), 138'(0));
        chk("rst_req", 138'(sram_if.data_sram_req), 138'(0));
        chk("rst_allowin", 138'(mem_allowin), 138'(1));
        rst = 1'b0;
        tick();

        // ALU entry handed off in its arrival cycle
        e = mk_ex(1'b1, 32'h1C00_0000, 1'b0, 1'b0, 1'b1, 32'h0, 5'd5, 32'h1234);
        sb_q.push_back(mk_wb(32'h1C00_0000, 1'b1, 5'd5, 32'h1234));
        fire_load(e);
        #2;
        chk("alu_allowin", 138'(mem_allowin), 138'(1));
        chk("alu_fvalid", 138'(front_valid), 138'(1));
        chk("alu_fready", 138'(front_ready), 138'(1));
        chk("alu_faddr", 138'(front_addr), 138'(5));
        chk("alu_fdata", 138'(front_data), 138'(32'h1234));
        tick();
        #2;
        chk("alu_held_fvalid", 138'(front_valid), 138'(0));
        chk("alu_held_req", 138'(sram_if.data_sram_req), 138'(0));

        // ld.w answered in the first eligible cycles
        e = mk_ex(1'b1, 32'h1C00_0004, 1'b0, 1'b1, 1'b1, 32'h11, 5'd7, 32'h1C00_0100);
        sb_q.push_back(mk_wb(32'h1C00_0004, 1'b1, 5'd7, 32'hDEAD_BEEF));
        fire_load(e);
        #2;
        chk("ld_c0_req", 138'(sram_if.data_sram_req), 138'(0));
        chk("ld_c0_fready", 138'(front_ready), 138'(0));
        chk("ld_c0_allowin", 138'(mem_allowin), 138'(0));
        tick();
        sram_if.data_sram_addr_ok = 1'b1;
        #2;
        chk("ld_c1_req", 138'(sram_if.data_sram_req), 138'(1));
        chk("ld_c1_we", 138'(sram_if.data_sram_we), 138'(0));
        chk("ld_c1_wr", 138'(sram_if.data_sram_wr), 138'(0));
        chk("ld_c1_addr", 138'(sram_if.data_sram_addr), 138'(32'h1C00_0100));
        chk("ld_c1_fready", 138'(front_ready), 138'(0));
        tick();
        sram_if.data_sram_addr_ok = 1'b0;
        sram_if.data_sram_data_ok = 1'b1;
        sram_if.data_sram_rdata   = 32'hDEAD_BEEF;
        #2;
        chk("ld_c2_req", 138'(sram_if.data_sram_req), 138'(0));
        chk("ld_c2_fready", 138'(front_ready), 138'(0));
        tick();
        sram_if.data_sram_data_ok = 1'b0;
        sram_if.data_sram_rdata   = 32'h0;
        #2;
        chk("ld_c3_fready", 138'(front_ready), 138'(1));
        chk("ld_c3_fdata", 138'(front_data), 138'(32'hDEAD_BEEF));
        chk("ld_c3_allowin", 138'(mem_allowin), 138'(1));
        tick();
        #2;
        chk("ld_after_fvalid", 138'(front_valid), 138'(0));

        // st.w with addr_ok withheld three cycles
        e = mk_ex(1'b1, 32'h1C00_0008, 1'b1, 1'b0, 1'b0, 32'hA5A5_A5A5, 5'd0, 32'h80);
        sb_q.push_back(mk_wb(32'h1C00_0008, 1'b0, 5'd0, 32'h80));
        fire_load(e);
        for (int i = 0; i < 4; i++) begin
            tick();
            sram_if.data_sram_addr_ok = (i == 3);
            #2;
            chk("st_req", 138'(sram_if.data_sram_req), 138'(1));
            chk("st_we", 138'(sram_if.data_sram_we), 138'(4'hF));
            chk("st_wr", 138'(sram_if.data_sram_wr), 138'(1));
            chk("st_addr", 138'(sram_if.data_sram_addr), 138'(32'h80));
            chk("st_wdata", 138'(sram_if.data_sram_wdata), 138'(32'hA5A5_A5A5));
            chk("st_allowin", 138'(mem_allowin), 138'(0));
        end
        tick();
        sram_if.data_sram_addr_ok = 1'b0;
        sram_if.data_sram_data_ok = 1'b1;
        #2;
        chk("st_wait_req", 138'(sram_if.data_sram_req), 138'(0));
        tick();
        sram_if.data_sram_data_ok = 1'b0;
        #2;
        chk("st_done_allowin", 138'(mem_allowin), 138'(1));
        chk("st_fvalid", 138'(front_valid), 138'(0));
        tick();

        // Load completing into a stalled writeback
        a0 = accepted;
        e = mk_ex(1'b1, 32'h1C00_000C, 1'b0, 1'b1, 1'b1, 32'h0, 5'd9, 32'h200);
        sb_q.push_back(mk_wb(32'h1C00_000C, 1'b1, 5'd9, 32'hCAFE_F00D));
        fire_load(e);
        tick();
        sram_if.data_sram_addr_ok = 1'b1;
        tick();
        sram_if.data_sram_addr_ok = 1'b0;
        sram_if.data_sram_data_ok = 1'b1;
        sram_if.data_sram_rdata   = 32'hCAFE_F00D;
        wb_allowin = 1'b0;
        tick();
        sram_if.data_sram_data_ok = 1'b0;
        sram_if.data_sram_rdata   = 32'h0BAD_0BAD;
        #2;
        chk("stall_c3_allowin", 138'(mem_allowin), 138'(0));
        chk("stall_c3_req", 138'(sram_if.data_sram_req), 138'(0));
        chk("stall_c3_fdata", 138'(front_data), 138'(32'hCAFE_F00D));
        tick();
        sram_if.data_sram_data_ok = 1'b1;
        #2;
        chk("stall_c4_fready", 138'(front_ready), 138'(1));
        chk("stall_c4_req", 138'(sram_if.data_sram_req), 138'(0));
        tick();
        sram_if.data_sram_data_ok = 1'b0;
        wb_allowin = 1'b1;
        #2;
        chk("stall_c5_allowin", 138'(mem_allowin), 138'(1));
        chk("stall_c5_fdata", 138'(front_data), 138'(32'hCAFE_F00D));
        repeat (3) tick();
        #2;
        chk("stall_bubble", 138'(mem_to_wb[70]), 138'(0));
        chk("stall_one_req", 138'(accepted - a0), 138'(1));
        chk("stall_req_idle", 138'(sram_if.data_sram_req), 138'(0));

        // Reset while waiting for data_ok, then a stray data_ok
        e = mk_ex(1'b1, 32'h1C00_0010, 1'b0, 1'b1, 1'b1, 32'h0, 5'd3, 32'h300);
        fire_load(e);
        tick();
        sram_if.data_sram_addr_ok = 1'b1;
        tick();
        sram_if.data_sram_addr_ok = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ex_reg = mk_ex(1'b0, 32'h1C00_0010, 1'b0, 1'b1, 1'b1, 32'h0, 5'd3, 32'h300);
        sram_if.data_sram_data_ok = 1'b1;
        sram_if.data_sram_rdata   = 32'h5555_5555;
        #2;
        chk("rstw_req", 138'(sram_if.data_sram_req), 138'(0));
        chk("rstw_wb_reg", 138'(mem_to_wb), 138'(0));
        chk("rstw_allowin", 138'(mem_allowin), 138'(1));
        chk("rstw_buf", 138'(front_data), 138'(0));
        tick();
        sram_if.data_sram_data_ok = 1'b0;
        sram_if.data_sram_rdata   = 32'h0;
        #2;
        chk("rstw_buf_after", 138'(front_data), 138'(0));
        chk("rstw_req_after", 138'(sram_if.data_sram_req), 138'(0));
        chk("rstw_wb_after", 138'(mem_to_wb), 138'(0));

        // Back-to-back ALU entries, one handoff per cycle
        for (int i = 0; i < 4; i++) begin
            bb[i] = mk_ex(1'b1, 32'h1C00_0100 + 32'(4 * i), 1'b0, 1'b0, 1'b1, 32'h0,
                          5'(10 + i), 32'h100 + 32'(i));
            sb_q.push_back(mk_wb(32'h1C00_0100 + 32'(4 * i), 1'b1, 5'(10 + i), 32'h100 + 32'(i)));
        end
        h0 = handoffs;
        fire = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            ex_reg = bb[i];
            fire   = (i < 3);
            #2;
            chk("b2b_allowin", 138'(mem_allowin), 138'(1));
            chk("b2b_fvalid", 138'(front_valid), 138'(1));
        end
        tick();
        #2;
        chk("b2b_count", 138'(handoffs - h0), 138'(4));
        chk("b2b_last_valid", 138'(mem_to_wb[70]), 138'(1));
        chk("b2b_held_fvalid", 138'(front_valid), 138'(0));
        tick();
        #2;
        chk("b2b_bubble", 138'(mem_to_wb[70]), 138'(0));
        tick();
        chk("sb_empty", 138'(sb_q.size()), 138'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage directly downstream of the execute stage.
- Consumes the 138-bit execute→memory register and performs ld.w/st.w through a request/address-ok/data-ok data-SRAM interface.
- Selects load data or the ALU result, forwards the pending register write to the decoder, and registers a 71-bit bundle for writeback.

Parameters:
- DATA_W, 32, data/address width; fixed, not overridable in this project.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- EX_to_MEM_reg  in  138  {valid, pc[31:0], IR[31:0], inst_ld_w, mem_we, res_from_mem, gr_we, rkd_value[31:0], rf_waddr[4:0], compute_result[31:0]}, MSB first
- EX_to_MEM_fire  in  1  high in the cycle upstream loads EX_to_MEM_reg (its readygo & MEM_allowin)
- WB_allowin  in  1  writeback can accept this cycle
- MEM_allowin  out  1  stage can accept a new entry
- MEM_front_valid  out  1  entry will write rf_waddr
- MEM_front_ready  out  1  MEM_front_data is final
- MEM_front_addr  out  5  destination register
- MEM_front_data  out  32  final result (buffered load data, or compute_result)
- data_sram_req  out  1  request valid
- data_sram_wr  out  1  1 = store
- data_sram_we  out  4  byte enables
- data_sram_addr  out  32  compute_result
- data_sram_wdata  out  32  rkd_value
- data_sram_addr_ok  in  1  request accepted
- data_sram_data_ok  in  1  response; rdata valid for loads
- data_sram_rdata  in  32  load data
- MEM_to_WB_reg  out  71  {valid, pc[31:0], gr_we, rf_waddr[4:0], final_result[31:0]}

Behaviour:
- Synchronous, active-high reset. Reset values:
  - state = IDLE, done = 0, rdata_buf = 0, MEM_to_WB_reg = 0.
  - data_sram_req = 0.
  - MEM_allowin = 1, because valid is 0 after the upstream reset.
- mem_op = res_from_mem | mem_we. All decoding uses the EX_to_MEM_reg fields.
- done flag marks the held entry as already handed off, since upstream holds its register when not reloading.
  - Next-state priority: EX_to_MEM_fire → 0; else handoff → 1; else hold.
- live = valid & ~done.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE: if live & mem_op → REQ. Non-memory entries never leave IDLE.
  - REQ: data_sram_req = 1. On addr_ok → WAIT, else stay. Address, data, wr and we are held stable while in REQ.
  - WAIT: on data_ok, latch rdata into rdata_buf (loads only) → DONE. data_ok arrives at least 1 cycle after addr_ok. data_ok outside WAIT is ignored.
  - DONE: on WB_allowin → IDLE.
- Request fields:
  - data_sram_wr = mem_we.
  - data_sram_we = mem_we ? 4'hF : 4'h0.
  - Word access only; alignment is guaranteed upstream.
- MEM_readygo = live & (~mem_op & state==IDLE | state==DONE).
- handoff = MEM_readygo & WB_allowin.
- MEM_allowin = ~valid | done | handoff.
- final_result = res_from_mem ? rdata_buf : compute_result. The raw rdata is never passed through combinationally.
- Forwarding:
  - MEM_front_valid = live & gr_we.
  - MEM_front_ready = ~res_from_mem | state==DONE.
  - MEM_front_addr = rf_waddr.
  - MEM_front_data = final_result.
  - The decoder stalls while valid & ~ready.
- Output register update on each edge (not reset):
  - handoff → {1, pc, gr_we, rf_waddr, final_result}.
  - else if WB_allowin → valid bit cleared (bubble), other bits don't-care.
  - else hold.
- Latency:
  - Non-memory entry: handed off in its arrival cycle.
  - Load/store with addr_ok and data_ok each answered in the first eligible cycle: arrival c0, req c1, WAIT c2, DONE c3, handoff c3.
- WB stall in DONE: stay in DONE and hold rdata_buf; no second request is issued.
- Reset mid-transaction: return to IDLE, drop req. Any later addr_ok/data_ok is ignored.

Test Plan:
- ALU entry, valid=1, gr_we=1, rf_waddr=5, compute_result=0x1234, WB_allowin=1 → same cycle MEM_allowin=1, front_valid=1, front_ready=1; next edge MEM_to_WB_reg = {1, pc, 1, 5, 0x1234}.
- ld.w with addr 0x1C000100, addr_ok at c1, data_ok at c2 with rdata=0xDEADBEEF → req high only in c1 with we=0, wr=0; front_ready=0 in c0–c2; MEM_to_WB_reg.final_result=0xDEADBEEF after c3.
- st.w with addr 0x80, rkd=0xA5A5A5A5, addr_ok withheld 3 cycles → req and fields held stable 4 cycles, we=4'hF, wr=1; handoff with gr_we=0 after data_ok.
- Load completes while WB_allowin=0 for 2 cycles, with upstream holding the register → exactly one request; DONE held; single handoff; no duplicate after done=1 until EX_to_MEM_fire.
- rst asserted in WAIT, then stray data_ok → state IDLE, req=0, MEM_to_WB_reg=0, rdata_buf unchanged by data_ok.
- Back-to-back ALU entries with fire every cycle and WB_allowin=1 → one handoff per cycle, no bubbles; with fire low after handoff → bubble written (valid=0).
